// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller and the hazard comparators.
package pipe_ctrl_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] R0 = 4'h0;

    typedef enum logic [2:0] {
        RUN,
        DWAIT,
        IWAIT,
        HALT,
        ERR
    } state_t;

    // Bit order matches the {wen..., flush...} concatenation used at the top-level outputs
    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic idex_wen;
        logic exmem_wen;
        logic memwb_wen;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds a source of the IF/ID instruction.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             memtoreg,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             uses_rs2,
    output logic             luse
);

    logic [REG_W-1:0] src [2];
    logic [1:0]       src_used;
    logic [1:0]       hit;

    assign src[0]   = rs1;
    assign src[1]   = rs2;
    assign src_used = {uses_rs2, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign hit[gi] = src_used[gi] && (src[gi] == rd);
        end
    endgenerate

    // R0 is hardwired zero, so a load targeting it never creates a dependency
    assign luse = memtoreg && (rd != R0) && (|hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: priority decisions are combinational,
// the wait/halt/error FSM and the stall performance counter are registered.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ifid_rs1,
    input  logic [3:0]       ifid_rs2,
    input  logic             ifid_uses_rs2,
    input  logic             idex_memtoreg,
    input  logic [3:0]       idex_rf_write_reg,
    input  logic             exmem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    input  logic             memwb_halt,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cycles_reg, stall_cycles_next;
    ctrl_t             ctrl;
    logic              dstall, istall, luse, mem_wait;

    assign dstall = dmem_req && !dmem_ready;
    assign istall = !imem_ready;

    hazard_detect u_hazard_detect (
        .memtoreg (idex_memtoreg),
        .rd       (idex_rf_write_reg),
        .rs1      (ifid_rs1),
        .rs2      (ifid_rs2),
        .uses_rs2 (ifid_uses_rs2),
        .luse     (luse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= RUN;
            wait_cnt_reg     <= '0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg        <= state_next;
            wait_cnt_reg     <= wait_cnt_next;
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    always_comb begin
        ctrl              = '0;
        state_next        = state_reg;
        wait_cnt_next     = wait_cnt_reg;
        stall_cycles_next = stall_cycles_reg;
        mem_wait          = 1'b0;
        case (state_reg)
            RUN, DWAIT, IWAIT: begin
                if (dstall) begin
                    // Drain the instruction already in MEM/WB, bubble behind it
                    ctrl.memwb_wen   = 1'b1;
                    ctrl.memwb_flush = 1'b1;
                    state_next       = DWAIT;
                    mem_wait         = 1'b1;
                end else if (exmem_branch_taken) begin
                    ctrl             = '{default: 1'b1};
                    ctrl.memwb_flush = 1'b0;
                    state_next       = RUN;
                end else if (luse) begin
                    ctrl.idex_wen    = 1'b1;
                    ctrl.idex_flush  = 1'b1;
                    ctrl.exmem_wen   = 1'b1;
                    ctrl.memwb_wen   = 1'b1;
                    state_next       = RUN;
                end else if (istall) begin
                    ctrl.ifid_wen    = 1'b1;
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_wen    = 1'b1;
                    ctrl.exmem_wen   = 1'b1;
                    ctrl.memwb_wen   = 1'b1;
                    state_next       = IWAIT;
                    mem_wait         = 1'b1;
                end else begin
                    ctrl.pc_wen      = 1'b1;
                    ctrl.ifid_wen    = 1'b1;
                    ctrl.idex_wen    = 1'b1;
                    ctrl.exmem_wen   = 1'b1;
                    ctrl.memwb_wen   = 1'b1;
                    state_next       = RUN;
                end

                if (mem_wait) begin
                    if (wait_cnt_reg == WAIT_MAX) begin
                        state_next = ERR;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    end
                end else begin
                    wait_cnt_next = '0;
                end

                // A retiring HLT wins over a timeout landing in the same cycle
                if (memwb_halt && ctrl.memwb_wen) begin
                    state_next = HALT;
                end

                if (!ctrl.pc_wen && (stall_cycles_reg != {CNT_W{1'b1}})) begin
                    stall_cycles_next = stall_cycles_reg + CNT_W'(1);
                end
            end
            default: begin
                // HALT and ERR freeze every stage until reset
            end
        endcase
    end

    assign pc_wen       = !rst && ctrl.pc_wen;
    assign ifid_wen     = !rst && ctrl.ifid_wen;
    assign idex_wen     = !rst && ctrl.idex_wen;
    assign exmem_wen    = !rst && ctrl.exmem_wen;
    assign memwb_wen    = !rst && ctrl.memwb_wen;
    assign ifid_flush   = !rst && ctrl.ifid_flush;
    assign idex_flush   = !rst && ctrl.idex_flush;
    assign exmem_flush  = !rst && ctrl.exmem_flush;
    assign memwb_flush  = !rst && ctrl.memwb_flush;
    assign halted       = (state_reg == HALT);
    assign err          = (state_reg == ERR);
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written multi-cycle sequences, random vs. model.
module tb_pipe_hazard_ctrl;

    localparam int TMO  = 8;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;
    localparam int M_RUN = 0, M_HALT = 1, M_ERR = 2;

    logic clk, rst;
    logic [3:0] ifid_rs1, ifid_rs2, idex_rf_write_reg;
    logic ifid_uses_rs2, idex_memtoreg, exmem_branch_taken;
    logic dmem_req, dmem_ready, imem_ready, memwb_halt;
    logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic halted, err;
    logic [CW-1:0] stall_cycles;
    logic [8:0] ctrl_obs;

    int n_vec  = 0;
    int n_miss = 0;
    int m_mode, m_wait, m_stalls;

    pipe_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .ifid_rs1           (ifid_rs1),
        .ifid_rs2           (ifid_rs2),
        .ifid_uses_rs2      (ifid_uses_rs2),
        .idex_memtoreg      (idex_memtoreg),
        .idex_rf_write_reg  (idex_rf_write_reg),
        .exmem_branch_taken (exmem_branch_taken),
        .dmem_req           (dmem_req),
        .dmem_ready         (dmem_ready),
        .imem_ready         (imem_ready),
        .memwb_halt         (memwb_halt),
        .pc_wen             (pc_wen),
        .ifid_wen           (ifid_wen),
        .idex_wen           (idex_wen),
        .exmem_wen          (exmem_wen),
        .memwb_wen          (memwb_wen),
        .ifid_flush         (ifid_flush),
        .idex_flush         (idex_flush),
        .exmem_flush        (exmem_flush),
        .memwb_flush        (memwb_flush),
        .halted             (halted),
        .err                (err),
        .stall_cycles       (stall_cycles)
    );

    assign ctrl_obs = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                       ifid_flush, idex_flush, exmem_flush, memwb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       uses;
        logic       mtr;
        logic [3:0] rd;
        logic       br;
        logic       dreq;
        logic       drdy;
        logic       irdy;
        logic       halt;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic uses,
                         input logic mtr, input logic [3:0] rd, input logic br,
                         input logic dreq, input logic drdy, input logic irdy, input logic halt);
        ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs2 = uses;
        idex_memtoreg = mtr; idex_rf_write_reg = rd; exmem_branch_taken = br;
        dmem_req = dreq; dmem_ready = drdy; imem_ready = irdy; memwb_halt = halt;
    endtask

    task automatic idle();
        drive(4'd1, 4'd2, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        #1;
        chk("reset ctrl", 16'(ctrl_obs), 16'h0);
        chk("reset stall_cycles", 16'(stall_cycles), 16'h0);
        chk("reset halted/err", {14'h0, halted, err}, 16'h0);
        tick();
        rst = 1'b0;
        m_mode = M_RUN; m_wait = 0; m_stalls = 0;
    endtask

    // Reference: outputs from the priority list, gated by the current mode
    function automatic logic [8:0] model_ctrl();
        bit dst, ist, lu;
        if (rst || m_mode != M_RUN) return 9'b0;
        dst = dmem_req && !dmem_ready;
        ist = !imem_ready;
        lu  = idex_memtoreg && idex_rf_write_reg != 0 &&
              (idex_rf_write_reg == ifid_rs1 || (ifid_uses_rs2 && idex_rf_write_reg == ifid_rs2));
        if (dst)                return 9'b00001_0001;
        if (exmem_branch_taken) return 9'b11111_1110;
        if (lu)                 return 9'b00111_0100;
        if (ist)                return 9'b01111_1000;
        return 9'b11111_0000;
    endfunction

    task automatic model_step(input logic [8:0] c);
        bit waiting;
        if (m_mode != M_RUN) return;
        if (!c[8]) m_stalls = (m_stalls < SMAX) ? m_stalls + 1 : SMAX;
        waiting = (dmem_req && !dmem_ready) || (!imem_ready && c == 9'b01111_1000);
        if (memwb_halt) m_mode = M_HALT;
        else if (waiting) begin
            if (m_wait + 1 >= TMO) m_mode = M_ERR;
            else m_wait++;
        end else m_wait = 0;
    endtask

    initial begin
        logic [8:0] e;
        rst = 1'b1;
        idle();

        //            rs1   rs2   use  mtr  rd    br   dreq drdy irdy hlt  expected
        vecs[0]  = '{4'd1, 4'd2, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b11111_0000};
        vecs[1]  = '{4'd3, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b00111_0100};
        vecs[2]  = '{4'd0, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b11111_0000};
        vecs[3]  = '{4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b00111_0100};
        vecs[4]  = '{4'd1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b11111_0000};
        vecs[5]  = '{4'd1, 4'd2, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'b00001_0001};
        vecs[6]  = '{4'd1, 4'd2, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'b11111_0000};
        vecs[7]  = '{4'd1, 4'd2, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b11111_1110};
        vecs[8]  = '{4'd3, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b11111_1110};
        vecs[9]  = '{4'd1, 4'd2, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b01111_1000};
        vecs[10] = '{4'd3, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00111_0100};
        vecs[11] = '{4'd1, 4'd2, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'b00001_0001};
        vecs[12] = '{4'd1, 4'd2, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b11111_1110};

        for (int i = 0; i < 13; i++) begin
            do_reset();
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].uses, vecs[i].mtr, vecs[i].rd,
                  vecs[i].br, vecs[i].dreq, vecs[i].drdy, vecs[i].irdy, vecs[i].halt);
            #1;
            chk($sformatf("vec%0d ctrl", i), 16'(ctrl_obs), 16'(vecs[i].exp));
            tick();
            chk($sformatf("vec%0d stall_cycles", i), 16'(stall_cycles), vecs[i].exp[8] ? 16'd0 : 16'd1);
        end

        // Data-memory miss for five cycles
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("dmiss cyc%0d ctrl", i), 16'(ctrl_obs), 16'(9'b00001_0001));
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        chk("dmiss release ctrl", 16'(ctrl_obs), 16'(9'b11111_0000));
        chk("dmiss stall_cycles", 16'(stall_cycles), 16'd5);
        tick();
        chk("dmiss no err", {14'h0, halted, err}, 16'h0);

        // Seven fetch stalls, one good fetch, seven more: counter must have cleared
        do_reset();
        imem_ready = 1'b0;
        repeat (TMO - 1) tick();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        repeat (TMO - 1) tick();
        chk("tmo-1 no err", 16'(err), 16'd0);

        // Fetch timeout, then asynchronous reset out of ERR
        do_reset();
        imem_ready = 1'b0;
        repeat (TMO) tick();
        chk("timeout err", 16'(err), 16'd1);
        chk("timeout ctrl", 16'(ctrl_obs), 16'h0);
        chk("timeout stall_cycles", 16'(stall_cycles), 16'd8);
        imem_ready = 1'b1;
        tick();
        chk("err absorbing ctrl", 16'(ctrl_obs), 16'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst err", 16'(err), 16'd0);
        chk("async rst stall_cycles", 16'(stall_cycles), 16'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("after rst ctrl", 16'(ctrl_obs), 16'(9'b11111_0000));

        // HLT retiring during a data stall
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0; memwb_halt = 1'b1;
        #1;
        chk("hlt+dstall ctrl", 16'(ctrl_obs), 16'(9'b00001_0001));
        tick();
        memwb_halt = 1'b0;
        chk("hlt halted", 16'(halted), 16'd1);
        chk("hlt ctrl", 16'(ctrl_obs), 16'h0);
        dmem_ready = 1'b1;
        repeat (3) tick();
        chk("hlt absorbing ctrl", 16'(ctrl_obs), 16'h0);
        chk("hlt still halted", 16'(halted), 16'd1);

        // Counter saturation via repeated load-use stalls
        do_reset();
        drive(4'd3, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (20) tick();
        chk("stall saturation", 16'(stall_cycles), 16'(SMAX));
        chk("saturation no err", {14'h0, halted, err}, 16'h0);

        // Random stimulus against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 4'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) == 0);
            e = model_ctrl();
            @(negedge clk);
            chk("rand ctrl", 16'(ctrl_obs), 16'(e));
            chk("rand halted", 16'(halted), 16'(m_mode == M_HALT));
            chk("rand err", 16'(err), 16'(m_mode == M_ERR));
            chk("rand stall_cycles", 16'(stall_cycles), 16'(m_stalls));
            @(posedge clk);
            model_step(e);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
